// File: rtl/cbus_rr_arbiter_pkg.sv
// CBus request/response bundles and arbiter state encoding,
// shared by the round-robin arbiter and its testbench.
package cbus_rr_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int LEN_W  = 4;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [2:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic              last;
        logic [DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the memory side.
// slave: the arbiter's view; master: the environment's view.
interface cbus_rr_arbiter_if #(
    parameter int NUM_INPUTS = 4
);
    import cbus_rr_arbiter_pkg::*;

    cbus_req_t  [NUM_INPUTS-1:0] ireqs;
    cbus_resp_t [NUM_INPUTS-1:0] iresps;
    cbus_req_t                   oreq;
    cbus_resp_t                  oresp;

    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq
    );

    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq
    );

endinterface

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Combinational priority rotator: first valid index at or after ptr_i,
// wrapping modulo N, so any N in 2..8 is handled.
module cbus_rr_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [IW:0] cand;

    // Walk from the farthest candidate down so the nearest one wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(N)) begin
                cand = cand - (IW + 1)'(N);
            end
            if (valid_i[cand[IW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin CBus arbiter with burst lock: the granted requester
// owns the bus until its last beat completes or it drops valid.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4
) (
    input  logic                clk,
    input  logic                reset,
    cbus_rr_arbiter_if.slave    bus
);

    localparam int IDX_W = $clog2(NUM_INPUTS);

    arb_state_t          state_q;
    logic [IDX_W-1:0]    sel_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    rr_ptr_d;
    logic [NUM_INPUTS-1:0] valid_vec;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                done;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valid_vec[i] = bus.ireqs[i].valid;
        end
    end

    cbus_rr_arbiter_rr_pick #(
        .N  (NUM_INPUTS),
        .IW (IDX_W)
    ) u_pick (
        .valid_i (valid_vec),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // The owner becomes lowest priority next round.
    assign rr_ptr_d = (sel_q == IDX_W'(NUM_INPUTS - 1)) ?
                      '0 : sel_q + 1'b1;

    assign done = !bus.ireqs[sel_q].valid ||
                  (bus.oresp.ready && bus.oresp.last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        sel_q   <= pick_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.oreq   = '0;
        bus.iresps = '0;
        if (state_q == BUSY) begin
            bus.oreq          = bus.ireqs[sel_q];
            bus.iresps[sel_q] = bus.oresp;
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed testbench for cbus_rr_arbiter with four requesters.
// Inputs change at posedge+1, outputs are checked at posedge+3.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int N = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    cbus_rr_arbiter_if #(.NUM_INPUTS(N)) bus ();

    cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cbus_req_t mk(int i, int len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = i[0];
        r.size     = 3'd2;
        r.addr     = 32'h1000 * (i + 1) + 32'h40;
        r.strobe   = 4'hf;
        r.data     = 32'hA000_0000 + i;
        r.len      = LEN_W'(len);
        return r;
    endfunction

    function automatic cbus_resp_t rsp(logic rdy, logic lst,
                                       logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    task automatic chk(string tag, logic [255:0] obs,
                       logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    cbus_req_t  r0, r1, r2, r3;
    cbus_resp_t rs;
    int         e;

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset with every requester valid
        reset = 1'b1;
        for (int i = 0; i < N; i++) bus.ireqs[i] = mk(i, 0);
        bus.oresp = '0;
        #1;
        chk("rst_oreq_t0", bus.oreq.valid, 1'b0);
        nxt();
        #2;
        chk("rst_oreq", bus.oreq.valid, 1'b0);
        chk("rst_iresps", bus.iresps, '0);
        nxt();
        reset = 1'b0;
        bus.oresp = rsp(1'b1, 1'b1, 32'hD0);
        #2;
        chk("post_rst_idle", bus.oreq.valid, 1'b0);

        // All valid, single-beat: 0,1,2,3,0 with a bubble each
        for (int k = 0; k < 5; k++) begin
            e = k % N;
            nxt();
            bus.oresp = rsp(1'b1, 1'b1, 32'hD0 + k);
            #2;
            r0 = mk(e, 0);
            rs = rsp(1'b1, 1'b1, 32'hD0 + k);
            chk($sformatf("rr_grant%0d", k), bus.oreq, r0);
            chk($sformatf("rr_resp%0d", k), bus.iresps[e], rs);
            chk($sformatf("rr_other%0d", k),
                bus.iresps[(e + 1) % N], '0);
            nxt();
            if (k == 4) bus.ireqs = '0;
            #2;
            chk($sformatf("rr_bubble%0d", k), bus.oreq.valid, 1'b0);
            chk($sformatf("rr_bub_rsp%0d", k), bus.iresps, '0);
        end

        // Only req2, 4-beat burst
        nxt();
        bus.oresp = '0;
        bus.ireqs[2] = mk(2, 3);
        #2;
        chk("b2_arb_cycle", bus.oreq.valid, 1'b0);
        for (int b = 0; b < 4; b++) begin
            nxt();
            bus.oresp = rsp(1'b1, b == 3, 32'hE0 + b);
            #2;
            r2 = mk(2, 3);
            rs = rsp(1'b1, b == 3, 32'hE0 + b);
            chk($sformatf("b2_oreq%0d", b), bus.oreq, r2);
            chk($sformatf("b2_resp%0d", b), bus.iresps[2], rs);
            chk($sformatf("b2_r0_%0d", b), bus.iresps[0], '0);
            chk($sformatf("b2_r1_%0d", b), bus.iresps[1], '0);
            chk($sformatf("b2_r3_%0d", b), bus.iresps[3], '0);
        end

        // rr_ptr=3: req3 beats req0, then req3 aborts
        nxt();
        bus.oresp = '0;
        bus.ireqs = '0;
        bus.ireqs[0] = mk(0, 0);
        bus.ireqs[3] = mk(3, 0);
        #2;
        chk("b2_done_idle", bus.oreq.valid, 1'b0);
        nxt();
        #2;
        r3 = mk(3, 0);
        chk("ptr3_grant3", bus.oreq, r3);
        nxt();
        bus.ireqs = '0;
        #2;
        chk("abort_oreq", bus.oreq.valid, 1'b0);
        chk("abort_rsp", bus.iresps, '0);

        // After abort rr_ptr=0: req1 beats req3
        nxt();
        bus.ireqs[1] = mk(1, 3);
        bus.ireqs[3] = mk(3, 0);
        #2;
        chk("abort_idle", bus.oreq.valid, 1'b0);
        nxt();
        bus.ireqs[3] = '0;
        #2;
        r1 = mk(1, 3);
        chk("ptr0_grant1", bus.oreq, r1);

        // Burst lock while req0 arrives mid-burst
        nxt();
        bus.ireqs[0] = mk(0, 3);
        bus.oresp = rsp(1'b1, 1'b0, 32'hF1);
        #2;
        rs = rsp(1'b1, 1'b0, 32'hF1);
        chk("lock_oreq1", bus.oreq, r1);
        chk("lock_resp1", bus.iresps[1], rs);
        chk("lock_rsp0", bus.iresps[0], '0);
        nxt();
        bus.oresp = rsp(1'b1, 1'b1, 32'hF2);
        #2;
        chk("lock_oreq2", bus.oreq, r1);
        nxt();
        bus.ireqs[1] = '0;
        bus.oresp = '0;
        #2;
        chk("lock_done_idle", bus.oreq.valid, 1'b0);
        nxt();
        bus.oresp = rsp(1'b1, 1'b0, 32'hC1);
        #2;
        r0 = mk(0, 3);
        chk("wrap_grant0", bus.oreq, r0);

        // Reset during beat 2
        nxt();
        bus.oresp = rsp(1'b1, 1'b0, 32'hC2);
        #1;
        chk("beat2_valid", bus.oreq.valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_oreq", bus.oreq.valid, 1'b0);
        chk("midrst_rsp", bus.iresps, '0);
        nxt();
        bus.ireqs = '0;
        bus.ireqs[1] = mk(1, 0);
        bus.ireqs[3] = mk(3, 0);
        bus.oresp = '0;
        #2;
        chk("midrst_hold", bus.oreq.valid, 1'b0);
        nxt();
        reset = 1'b0;
        #2;
        chk("midrst_idle", bus.oreq.valid, 1'b0);
        nxt();
        #2;
        r1 = mk(1, 0);
        chk("midrst_grant1", bus.oreq, r1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
